// File: rtl/simd_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : simd_wb_queue
//  Purpose  : Writeback queue behind the SIMD integer unit. Each issued op's
//             destination tag travels down a LAT-stage tag pipe that is
//             aligned with the SIMD result pipeline. When the tag exits, the
//             68-bit result is paired with it and written into a DEPTH-entry
//             FIFO. The FIFO drains to a register-file write port over
//             valid/ready. An issue credit (can_issue) guarantees that every
//             accepted op already has a reserved FIFO slot.
//
//  Ports    : clk        clock; all state changes on the falling edge
//             rst        synchronous, active-high reset
//             flush      drop all in-flight and queued results
//             issue_en   SIMD op issued this cycle
//             issue_reg  destination register tag of the issued op
//             can_issue  credit: an issue this cycle has a guaranteed slot
//             simd_res   SIMD result {ptype[1:0], payload[65:0]}
//             wb_valid   head entry valid
//             wb_reg     head entry destination tag
//             wb_data    head entry result (unmodified)
//             wb_ready   register file accepts the head this cycle
//             ovf_err    sticky overflow flag, cleared only by rst
//
//  Config   : SIMD_WBQ_BYPASS_EN - when defined, a result leaving the tag
//             pipe while the FIFO is empty is presented combinationally on
//             the writeback port in the same cycle, and is only written into
//             the FIFO if the register file does not take it.
//
//  Revision : 1.0 - initial release
// ============================================================================
module simd_wb_queue #(
    parameter int LAT   = 2,
    parameter int DEPTH = 4,
    parameter int REG_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             issue_en,
    input  logic [REG_W-1:0] issue_reg,
    output logic             can_issue,
    input  logic [67:0]      simd_res,
    output logic             wb_valid,
    output logic [REG_W-1:0] wb_reg,
    output logic [67:0]      wb_data,
    input  logic             wb_ready,
    output logic             ovf_err
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_INF_W = $clog2(LAT + 1);
    localparam int c_OCC_W = $clog2(DEPTH + LAT + 1);

    // Tag pipe
    logic [LAT-1:0]     r_vld;
    logic [REG_W-1:0]   r_tag [LAT];

    // FIFO storage and bookkeeping
    logic [REG_W-1:0]   r_mem_tag  [DEPTH];
    logic [67:0]        r_mem_data [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_ovf_err;

    logic [c_INF_W-1:0] w_inflight;
    logic [c_OCC_W-1:0] w_occ;
    logic               w_exit_vld;
    logic [REG_W-1:0]   w_exit_tag;
    logic               w_nempty;
    logic               w_full;
    logic               w_bypass;
    logic               w_pop;
    logic               w_push_req;
    logic               w_push;
    logic               w_push_ovf;
    logic               w_issue_ok;
    logic               w_issue_ovf;

    // ------------------------------------------------------------------
    // Credit: every valid tag-pipe stage already owns a future FIFO slot,
    // so occupancy counts both queued and in-flight results. Built from
    // registers only so the scheduler sees a stable value all cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            w_inflight = w_inflight + c_INF_W'(r_vld[i]);
        end
        w_occ     = c_OCC_W'(r_count) + c_OCC_W'(w_inflight);
        can_issue = (w_occ < c_OCC_W'(DEPTH));
    end

    always_comb begin
        w_exit_vld = r_vld[LAT-1];
        w_exit_tag = r_tag[LAT-1];
        w_nempty   = (r_count != '0);
        w_full     = (r_count == c_CNT_W'(DEPTH));

`ifdef SIMD_WBQ_BYPASS_EN
        w_bypass   = w_exit_vld & ~w_nempty;
`else
        w_bypass   = 1'b0;
`endif

        // A bypassed result that is taken immediately never enters the FIFO.
        w_pop       = w_nempty & wb_ready;
        w_push_req  = w_exit_vld & ~(w_bypass & wb_ready);
        // A full FIFO still accepts a push when the head leaves on the same edge.
        w_push      = w_push_req & (~w_full | w_pop);
        w_push_ovf  = w_push_req & w_full & ~w_pop;
        w_issue_ok  = issue_en & can_issue;
        w_issue_ovf = issue_en & ~can_issue;
    end

    // ------------------------------------------------------------------
    // Writeback port: head of FIFO, or the exiting result when bypassing.
    // Zero when nothing is presented so reset/flush give clean outputs.
    // ------------------------------------------------------------------
    always_comb begin
        wb_valid = w_nempty | w_bypass;
        wb_reg   = '0;
        wb_data  = '0;
        if (w_nempty) begin
            wb_reg  = r_mem_tag[r_rd_ptr];
            wb_data = r_mem_data[r_rd_ptr];
        end else if (w_bypass) begin
            wb_reg  = w_exit_tag;
            wb_data = simd_res;
        end
    end

    assign ovf_err = r_ovf_err;

    // Tag values carry no meaning without their vld bit, so no reset needed.
    always_ff @(negedge clk) begin
        r_tag[0] <= issue_reg;
        for (int i = 1; i < LAT; i++) begin
            r_tag[i] <= r_tag[i-1];
        end
    end

    always_ff @(negedge clk) begin
        if (w_push && !rst && !flush) begin
            r_mem_tag[r_wr_ptr]  <= w_exit_tag;
            r_mem_data[r_wr_ptr] <= simd_res;
        end
    end

    // Control state: flush behaves like a reset of the queue, except the
    // sticky error flag is preserved.
    always_ff @(negedge clk) begin
        if (rst || flush) begin
            r_vld    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_vld[0] <= w_issue_ok;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
        end else if (!flush && (w_issue_ovf || w_push_ovf)) begin
            r_ovf_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_simd_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simd_wb_queue
//  Purpose  : Directed scoreboard bench for simd_wb_queue. The driver pushes
//             the expected {tag, data} of each op it expects to be accepted;
//             a separate monitor pops and compares on every writeback
//             transfer. Register-visible status is checked directly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_simd_wb_queue;

    localparam int LAT = 2;

`ifdef SIMD_WBQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic        issue_en;
    logic [8:0]  issue_reg;
    logic        can_issue;
    logic [67:0] simd_res;
    logic        wb_valid;
    logic [8:0]  wb_reg;
    logic [67:0] wb_data;
    logic        wb_ready;
    logic        ovf_err;

    logic [67:0] issue_data;
    logic [67:0] su [LAT];

    logic [76:0] exp_q [$];
    int          n_vec;
    int          n_err;

    simd_wb_queue #(.LAT(LAT), .DEPTH(4), .REG_W(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .issue_en  (issue_en),
        .issue_reg (issue_reg),
        .can_issue (can_issue),
        .simd_res  (simd_res),
        .wb_valid  (wb_valid),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .wb_ready  (wb_ready),
        .ovf_err   (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SIMD unit stand-in: result appears LAT falling edges after issue.
    always @(negedge clk) begin
        su[0] <= issue_data;
        for (int i = 1; i < LAT; i++) begin
            su[i] <= su[i-1];
        end
    end
    assign simd_res = su[LAT-1];

    function automatic logic [67:0] mkd(input logic [8:0] t);
        mkd = {t[1:0], 25'h155AAAA, 30'h0, t, ~t[1:0]};
    endfunction

    task automatic chk(input string name, input logic [76:0] act, input logic [76:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // One cycle: inputs change 1 time unit after the rising edge; returns
    // at +2 so callers can check state left by the previous falling edge.
    task automatic cyc(input logic ie, input logic [8:0] r, input logic [67:0] d,
                       input logic acc, input logic rdy, input logic fl, input logic rs);
        @(posedge clk);
        #1;
        rst        = rs;
        flush      = fl;
        issue_en   = ie;
        issue_reg  = r;
        issue_data = d;
        wb_ready   = rdy;
        if (ie && acc) exp_q.push_back({r, d});
        #1;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 9'h0, 68'h0, 1'b0, rdy, 1'b0, 1'b0);
    endtask

    // Monitor: compare every transfer against the scoreboard head.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (rst || flush) begin
                exp_q.delete();
            end else if (wb_valid && wb_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL wb_unexpected: got reg=%0h data=%0h expected no transfer", wb_reg, wb_data);
                end else begin
                    logic [76:0] e;
                    e = exp_q.pop_front();
                    if ({wb_reg, wb_data} !== e) begin
                        n_err++;
                        $display("FAIL wb_xfer: got %0h expected %0h", {wb_reg, wb_data}, e);
                    end
                end
            end
        end
    end

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        flush      = 1'b0;
        issue_en   = 1'b0;
        issue_reg  = 9'h0;
        issue_data = 68'h0;
        wb_ready   = 1'b0;

        // Reset state
        cyc(1'b0, 9'h0, 68'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 9'h0, 68'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        chk("rst_wb_valid",  77'(wb_valid),  77'(0));
        chk("rst_wb_reg",    77'(wb_reg),    77'(0));
        chk("rst_wb_data",   77'(wb_data),   77'(0));
        chk("rst_ovf_err",   77'(ovf_err),   77'(0));
        chk("rst_can_issue", 77'(can_issue), 77'(1));

        // Single op, reg 0x05, data 0x1234
        cyc(1'b1, 9'h05, 68'h1234, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("single_credit", 77'(can_issue), 77'(1));
        idle(1'b1);
        chk("single_v1", 77'(wb_valid), 77'(0));
        idle(1'b1);
        chk("single_v2", 77'(wb_valid), 77'(BYP));
        idle(1'b1);
        chk("single_v3", 77'(wb_valid), 77'(!BYP));
        idle(1'b1);
        chk("single_v4", 77'(wb_valid), 77'(0));

        // Back-pressure: four credits, then none until first pop
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 9'h10 + 9'(i), mkd(9'h10 + 9'(i)), 1'b1, 1'b0, 1'b0, 1'b0);
            chk("bp_credit_on", 77'(can_issue), 77'(1));
        end
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            chk("bp_credit_off", 77'(can_issue), 77'(0));
        end
        idle(1'b1);
        chk("bp_full_credit", 77'(can_issue), 77'(0));
        chk("bp_full_valid",  77'(wb_valid),  77'(1));
        idle(1'b1);
        chk("bp_credit_back", 77'(can_issue), 77'(1));
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("bp_drained", 77'(wb_valid), 77'(0));
        chk("bp_ovf",     77'(ovf_err),  77'(0));

        // Wrap: tags 0..9, ready toggling 1,0,...
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) begin
                cyc(1'b1, 9'(k / 2), mkd(9'(k / 2)), 1'b1, 1'b1, 1'b0, 1'b0);
                chk("wrap_credit", 77'(can_issue), 77'(1));
            end else begin
                idle(1'b0);
            end
        end
        for (int k = 0; k < 4; k++) idle(1'b1);
        chk("wrap_drained", 77'(wb_valid), 77'(0));
        chk("wrap_ovf",     77'(ovf_err),  77'(0));

        // Forced overflow
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 9'h20 + 9'(i), mkd(9'h20 + 9'(i)), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b1, 9'h2F, mkd(9'h2F), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovf_credit",  77'(can_issue), 77'(0));
        chk("ovf_pre",     77'(ovf_err),   77'(0));
        idle(1'b0);
        chk("ovf_set",     77'(ovf_err),   77'(1));
        idle(1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        chk("ovf_sticky",  77'(ovf_err),   77'(1));
        chk("ovf_drained", 77'(wb_valid),  77'(0));
        cyc(1'b0, 9'h0, 68'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        chk("ovf_cleared", 77'(ovf_err),   77'(0));

        // Flush with 2 queued + 1 in flight and a same-cycle issue
        cyc(1'b1, 9'h30, mkd(9'h30), 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 9'h31, mkd(9'h31), 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        cyc(1'b1, 9'h32, mkd(9'h32), 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 9'h33, mkd(9'h33), 1'b0, 1'b0, 1'b1, 1'b0);
        chk("flush_pre_valid", 77'(wb_valid), 77'(1));
        idle(1'b0);
        chk("flush_valid",  77'(wb_valid),  77'(0));
        chk("flush_credit", 77'(can_issue), 77'(1));
        chk("flush_ovf",    77'(ovf_err),   77'(0));
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            chk("flush_no_stale", 77'(wb_valid), 77'(0));
        end

        // Reset mid-drain
        cyc(1'b1, 9'h40, mkd(9'h40), 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 9'h41, mkd(9'h41), 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("rmd_valid", 77'(wb_valid), 77'(1));
        chk("rmd_reg",   77'(wb_reg),   77'(9'h40));
        cyc(1'b0, 9'h0, 68'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rmd_hold", 77'(wb_valid), 77'(1));
        idle(1'b0);
        chk("rmd_wb_valid",  77'(wb_valid),  77'(0));
        chk("rmd_wb_data",   77'(wb_data),   77'(0));
        chk("rmd_wb_reg",    77'(wb_reg),    77'(0));
        chk("rmd_can_issue", 77'(can_issue), 77'(1));

        idle(1'b1);
        idle(1'b1);
        chk("scoreboard_empty", 77'(exp_q.size()), 77'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
